// File: rtl/lfsr_prng_stream_pkg.sv
// Shared definitions for the LFSR PRNG stream: FSM states, reference
// maximal-length XNOR tap sets and a constant clog2 helper.
package lfsr_prng_stream_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // XAPP052 XNOR taps, tap n mapped to bit n-1 of the Galois register.
    localparam logic [3:0]  LFSR_TAP_4  = 4'b1100;
    localparam logic [7:0]  LFSR_TAP_8  = 8'b1011_1000;
    localparam logic [15:0] LFSR_TAP_16 = 16'hD008;
    localparam logic [31:0] LFSR_TAP_32 = 32'h8020_0003;

    function automatic int unsigned lfsr_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_prng_stream_step.sv
// Combinational Galois XNOR LFSR: advances STEPS steps and reports the
// emitted bits, first emitted bit in bits_o[0].
module galois_lfsr_step #(
    parameter int unsigned              LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_TAP   = LFSR_WIDTH'(32'h8020_0003),
    parameter int unsigned              STEPS      = 1
) (
    input  logic [LFSR_WIDTH-1:0] state_i,
    output logic [LFSR_WIDTH-1:0] next_o,
    output logic [STEPS-1:0]      bits_o
);

    function automatic logic [LFSR_WIDTH-1:0] step1(input logic [LFSR_WIDTH-1:0] s);
        logic [LFSR_WIDTH-1:0] n;
        n[LFSR_WIDTH-1] = s[0];
        for (int unsigned i = 0; i < LFSR_WIDTH - 1; i++) begin
            n[i] = LFSR_TAP[i] ? ~(s[i+1] ^ s[0]) : s[i+1];
        end
        return n;
    endfunction

    logic [LFSR_WIDTH-1:0] walk;

    always_comb begin
        walk   = state_i;
        bits_o = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            bits_o[k] = walk[0];
            walk      = step1(walk);
        end
        next_o = walk;
    end

endmodule

// File: rtl/lfsr_prng_stream.sv
// Galois XNOR LFSR PRNG with LSB-first word assembly and a registered
// valid/ready output; the LFSR holds while a finished word cannot be handed off.
module lfsr_prng_stream
    import lfsr_prng_stream_pkg::*;
#(
    parameter int unsigned              LFSR_WIDTH    = 32,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_TAP      = LFSR_WIDTH'(LFSR_TAP_32),
    parameter int unsigned              OUT_WIDTH     = 32,
    parameter int unsigned              STEPS_PER_CLK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned STEP_N = (STEPS_PER_CLK == 0) ? 1 : STEPS_PER_CLK;
    localparam int unsigned CHUNKS = OUT_WIDTH / STEP_N;
    localparam int unsigned CW     = (CHUNKS > 1) ? lfsr_clog2(CHUNKS) : 1;
    localparam int unsigned AW     = (CHUNKS > 1) ? OUT_WIDTH - STEP_N : 1;

    if (LFSR_WIDTH < 3) begin : g_chk_width
        $fatal(1, "lfsr_prng_stream: LFSR_WIDTH must be >= 3");
    end
    if (LFSR_TAP[LFSR_WIDTH-1] == 1'b0) begin : g_chk_tap
        $fatal(1, "lfsr_prng_stream: LFSR_TAP MSB must be set");
    end
    if (STEPS_PER_CLK == 0) begin : g_chk_steps
        $fatal(1, "lfsr_prng_stream: STEPS_PER_CLK must be non-zero");
    end
    if ((STEPS_PER_CLK != 0) && (OUT_WIDTH % STEPS_PER_CLK != 0)) begin : g_chk_div
        $fatal(1, "lfsr_prng_stream: STEPS_PER_CLK must divide OUT_WIDTH");
    end

    state_e                state_q;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;
    logic [CW-1:0]         cnt_q;
    logic [AW-1:0]         asm_q;
    logic [AW-1:0]         asm_d;
    logic [OUT_WIDTH-1:0]  word_d;
    logic [OUT_WIDTH-1:0]  out_data_q;
    logic                  out_valid_q;
    logic [STEP_N-1:0]     step_bits;
    logic                  last;
    logic                  hs;
    logic                  out_free;

    galois_lfsr_step #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .LFSR_TAP   (LFSR_TAP),
        .STEPS      (STEP_N)
    ) u_step (
        .state_i (lfsr_q),
        .next_o  (lfsr_d),
        .bits_o  (step_bits)
    );

    // New chunks enter at the top and slide down, so the first chunk ends at bit 0.
    if (CHUNKS > 1) begin : g_asm
        assign word_d = {step_bits, asm_q};
        assign asm_d  = word_d[OUT_WIDTH-1:STEP_N];
    end else begin : g_noasm
        assign word_d = step_bits;
        assign asm_d  = '0;
    end

    assign last     = (cnt_q == CW'(CHUNKS - 1));
    assign hs       = out_valid_q & out_ready;
    assign out_free = ~out_valid_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            lfsr_q      <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (seed_load) begin
            state_q     <= ST_FILL;
            lfsr_q      <= (seed_in == '1) ? '0 : seed_in;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (hs) out_valid_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    ST_FILL: begin
                        if (!last) begin
                            lfsr_q <= lfsr_d;
                            asm_q  <= asm_d;
                            cnt_q  <= cnt_q + CW'(1);
                        end else if (out_free) begin
                            lfsr_q      <= lfsr_d;
                            out_data_q  <= word_d;
                            out_valid_q <= 1'b1;
                            asm_q       <= '0;
                            cnt_q       <= '0;
                        end else begin
                            state_q <= ST_STALL;
                        end
                    end
                    ST_STALL: begin
                        if (out_free) begin
                            lfsr_q      <= lfsr_d;
                            out_data_q  <= word_d;
                            out_valid_q <= 1'b1;
                            asm_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= ST_FILL;
                        end
                    end
                    default: state_q <= ST_FILL;
                endcase
            end
            // All-ones is the XNOR lock-up state; recover rather than stick.
            if (lfsr_q == '1) lfsr_q <= '0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
